pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/hazard_detect.sv | 17 +
 rtl/pipeline_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/halt controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] DRAIN_CYCLES = 2'd3;
    localparam logic [4:0] REG_ZERO     = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard: the ID instruction needs a register the load in EX has not produced yet.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       load_ex,
    input  logic [4:0] rt_ex,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       uses_rt_id,
    output logic       load_use
);

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign load_use = load_ex && (rt_ex != REG_ZERO) &&
                      ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: freeze on memory busy, branch flush, load-use bubble and halt drain.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | normal issue; branch flush / load-use bubble / halt detect
// ST_DRAIN | halt seen in ID; front end frozen while older instrs retire
// ST_HALT  | pipeline drained; stays here until reset
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_b,
    input  logic        mem_busy,
    input  logic        branch_taken_ex,
    input  logic        load_ex,
    input  logic [4:0]  rt_ex,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        uses_rt_id,
    input  logic        halted_id,
    output logic        pc_we,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    ctrl_state_t state;
    logic [1:0]  drain_cnt;
    logic        load_use;
    logic        start_drain;

    hazard_detect u_hazard_detect (
        .load_ex    (load_ex),
        .rt_ex      (rt_ex),
        .rs_id      (rs_id),
        .rt_id      (rt_id),
        .uses_rt_id (uses_rt_id),
        .load_use   (load_use)
    );

    always_comb begin
        pc_we       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        start_drain = 1'b0;
        if (mem_busy) begin
            pc_we    = 1'b0;
            if_id_en = 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    // a taken branch squashes a wrong-path halt sitting in ID
                    if (branch_taken_ex) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (halted_id) begin
                        pc_we       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        start_drain = 1'b1;
                    end else if (load_use) begin
                        pc_we       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    pc_we       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
                default: begin
                    pc_we    = 1'b0;
                    if_id_en = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= ST_RUN;
            drain_cnt <= 2'd0;
            halted    <= 1'b0;
            stall_cnt <= 16'd0;
        end else begin
            if ((state != ST_HALT) && !pc_we && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (!mem_busy) begin
                case (state)
                    ST_RUN: begin
                        if (start_drain) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DRAIN_CYCLES;
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_cnt == 2'd1) begin
                            state     <= ST_HALT;
                            halted    <= 1'b1;
                            drain_cnt <= 2'd0;
                        end else begin
                            drain_cnt <= drain_cnt - 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
